// File: rtl/mac_vector_sequencer.sv
// Sequencer for one MAC lane: buffers an input frame, replays it against every
// output index's weights, frames the sums with new_sum and collects the results.
module mac_vector_sequencer #(
  parameter int LOG2_NO_VECS = 2,
  parameter int BW_IN        = 16,
  parameter int BW_W         = 2,
  parameter int BW_OUT       = 16,
  parameter int NUM_CYC      = 32,
  parameter int NUM_OUT      = 8,
  parameter int RES_LAT      = 4,
  localparam int NO_VECS     = 1 << LOG2_NO_VECS,
  localparam int AW          = $clog2(NUM_OUT * NUM_CYC),
  localparam int IW          = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [NO_VECS*BW_IN-1:0]  in_data,
  output logic [AW-1:0]             w_addr,
  input  logic [NO_VECS*BW_W-1:0]   w_data,
  output logic                      mac_new_sum,
  output logic [NO_VECS*BW_IN-1:0]  mac_data,
  output logic [NO_VECS*BW_W-1:0]   mac_w,
  input  logic [BW_OUT-1:0]         mac_result,
  output logic                      out_vld,
  output logic [BW_OUT-1:0]         out_data,
  output logic [IW-1:0]             out_idx,
  output logic                      busy
);

  localparam int CW = $clog2(NUM_CYC);
  localparam logic [CW-1:0] LAST_C = CW'(NUM_CYC - 1);
  localparam logic [IW-1:0] LAST_O = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {LOAD, RUN, FLUSH, DRAIN} state_t;

  state_t state, state_nxt;

  logic [NO_VECS*BW_IN-1:0] buffer [NUM_CYC];
  logic [CW-1:0]            ld_cnt;
  logic [CW-1:0]            c;
  logic [IW-1:0]            o;
  logic [AW-1:0]            addr;
  logic                     iss_vld;
  logic                     tag_push;
  logic [RES_LAT-1:0]       tags;
  logic [IW-1:0]            res_cnt;
  logic                     accept;
  logic                     tag_exit;

  assign accept   = in_vld && in_rdy;
  assign tag_exit = tags[RES_LAT-1];
  assign w_addr   = addr;
  // The ROM output is already registered and arrives in the issue cycle, so it
  // is gated rather than re-registered to stay aligned with mac_data.
  assign mac_w    = iss_vld ? w_data : '0;

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_rdy = 1'b1;
        busy   = 1'b0;
        if (accept && ld_cnt == LAST_C) state_nxt = RUN;
      end
      RUN:     if (c == LAST_C && o == LAST_O) state_nxt = FLUSH;
      FLUSH:   state_nxt = DRAIN;
      DRAIN:   if (tag_exit && res_cnt == LAST_O) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) buffer[ld_cnt] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      ld_cnt      <= '0;
      c           <= '0;
      o           <= '0;
      addr        <= '0;
      iss_vld     <= 1'b0;
      mac_new_sum <= 1'b0;
      mac_data    <= '0;
      tag_push    <= 1'b0;
      tags        <= '0;
      res_cnt     <= '0;
      out_vld     <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
    end else begin
      state <= state_nxt;

      if (accept) ld_cnt <= (ld_cnt == LAST_C) ? '0 : ld_cnt + 1'b1;

      iss_vld     <= 1'b0;
      mac_new_sum <= 1'b0;
      mac_data    <= '0;
      tag_push    <= 1'b0;
      if (state == RUN) begin
        iss_vld     <= 1'b1;
        mac_data    <= buffer[c];
        mac_new_sum <= (c == '0);
        // The first sum of a frame has nothing before it to close.
        tag_push    <= (c == '0) && (o != '0);
        if (c == LAST_C) begin
          c    <= '0;
          o    <= (o == LAST_O) ? '0 : o + 1'b1;
          addr <= (o == LAST_O) ? '0 : addr + 1'b1;
        end else begin
          c    <= c + 1'b1;
          addr <= addr + 1'b1;
        end
      end else if (state == FLUSH) begin
        mac_new_sum <= 1'b1;
        tag_push    <= 1'b1;
      end

      tags[0] <= tag_push;
      for (int unsigned i = 1; i < RES_LAT; i++) tags[i] <= tags[i-1];

      out_vld <= tag_exit;
      if (tag_exit) begin
        out_data <= mac_result;
        out_idx  <= res_cnt;
        res_cnt  <= (res_cnt == LAST_O) ? '0 : res_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Directed bench for mac_vector_sequencer with a behavioural weight ROM and
// a delayed-accumulator MAC lane model.
module tb_mac_vector_sequencer;

  localparam int NC = 2;
  localparam int NO = 3;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] in_data;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic        mac_new_sum;
  logic [63:0] mac_data;
  logic [15:0] mac_w;
  logic [15:0] mac_result;
  logic        out_vld;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mac_vector_sequencer #(
    .LOG2_NO_VECS(2), .BW_IN(16), .BW_W(4), .BW_OUT(16),
    .NUM_CYC(NC), .NUM_OUT(NO), .RES_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data), .mac_new_sum(mac_new_sum),
    .mac_data(mac_data), .mac_w(mac_w), .mac_result(mac_result),
    .out_vld(out_vld), .out_data(out_data), .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous weight ROM
  logic [15:0] rom [8];
  always @(posedge clk) w_data <= rom[w_addr];

  // MAC lane model: new_sum closes the running sum, which appears RL cycles later
  logic signed [31:0] acc = 0;
  logic signed [31:0] prod;
  logic [15:0] mdly [RL];
  always_comb begin
    prod = 0;
    for (int i = 0; i < 4; i++)
      prod = prod + $signed(mac_data[i*16 +: 16]) * $signed(mac_w[i*4 +: 4]);
  end
  always @(posedge clk) begin
    if (mac_new_sum) begin
      mdly[0] <= acc[15:0];
      acc     <= prod;
    end else begin
      mdly[0] <= 16'hDEAD;
      acc     <= acc + prod;
    end
    for (int i = 1; i < RL; i++) mdly[i] <= mdly[i-1];
  end
  assign mac_result = mdly[RL-1];

  // Monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          last_acc, ns_n, res_n, busy_n;
  int          ns_cyc  [16];
  bit          ns_zero [16];
  logic [15:0] rd [8];
  logic [1:0]  ri [8];
  always @(negedge clk) begin
    if (in_vld && in_rdy) last_acc = cyc;
    if (mac_new_sum) begin
      if (ns_n < 16) begin
        ns_cyc[ns_n]  = cyc;
        ns_zero[ns_n] = (mac_data == '0) && (mac_w == '0);
      end
      ns_n++;
    end
    if (out_vld) begin
      if (res_n < 8) begin
        rd[res_n] = out_data;
        ri[res_n] = out_idx;
      end
      res_n++;
    end
    if (busy && !in_rdy) busy_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 0: w=1, 1: w=o+1, 2: w=-1, 3: w=1 for chunk 0 and 2 for chunk 1
  task automatic set_rom(input int mode);
    logic [3:0] wv;
    for (int o = 0; o < NO; o++)
      for (int c = 0; c < NC; c++) begin
        case (mode)
          0: wv = 4'd1;
          1: wv = 4'(o + 1);
          2: wv = 4'hF;
          default: wv = (c == 0) ? 4'd1 : 4'd2;
        endcase
        rom[o*NC + c] = {4{wv}};
      end
  endtask

  task automatic load(input logic [15:0] d0, input logic [15:0] d1, input bit gaps);
    for (int k = 0; k < NC; k++) begin
      if (gaps) begin
        in_vld = 1'b0;
        @(posedge clk); #1;
      end
      in_vld  = 1'b1;
      in_data = {4{(k == 0) ? d0 : d1}};
      @(posedge clk); #1;
    end
    in_vld = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                           input bit gaps, input bit hammer,
                           input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    logic [15:0] ex [3];
    int t;
    ex = '{e0, e1, e2};
    ns_n = 0; res_n = 0; busy_n = 0;
    load(d0, d1, gaps);
    if (hammer) begin
      in_vld  = 1'b1;
      in_data = '1;
    end
    t = 0;
    while (!in_rdy && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    in_vld = 1'b0;
    @(negedge clk); #1;
    check({tag, "_timeout"}, 32'(t < 100), 1);
    check({tag, "_busy_len"}, busy_n, NO*NC + RL + 2);
    check({tag, "_ns_count"}, ns_n, NO + 1);
    check({tag, "_ns_first"}, ns_cyc[0] - last_acc, 2);
    for (int i = 1; i <= NO; i++) check({tag, "_ns_gap"}, ns_cyc[i] - ns_cyc[i-1], NC);
    for (int i = 0; i < NO; i++) check({tag, "_ns_nonzero"}, 32'(ns_zero[i]), 0);
    check({tag, "_flush_zero"}, 32'(ns_zero[NO]), 1);
    check({tag, "_res_count"}, res_n, NO);
    for (int i = 0; i < NO; i++) begin
      check({tag, "_data"}, rd[i], ex[i]);
      check({tag, "_idx"}, ri[i], 32'(i));
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; in_vld = 1'b0; in_data = '0;
    ns_n = 0; res_n = 0; busy_n = 0; last_acc = 0;
    set_rom(0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy", in_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_new_sum", mac_new_sum, 0);
    check("rst_mac_data", mac_data, 0);
    check("rst_mac_w", mac_w, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_out", {out_data, 14'd0, out_idx}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_rom(0); run_frame("ones", 16'd1, 16'd1, 0, 0, 16'd8, 16'd8, 16'd8);
    set_rom(1); run_frame("ramp", 16'd1, 16'd1, 0, 0, 16'd8, 16'd16, 16'd24);
    set_rom(2); run_frame("neg", 16'd1, 16'd1, 0, 0, 16'hFFF8, 16'hFFF8, 16'hFFF8);
    set_rom(3); run_frame("order", 16'd1, 16'd3, 0, 0, 16'd28, 16'd28, 16'd28);
    set_rom(3); run_frame("gaps", 16'd1, 16'd3, 1, 0, 16'd28, 16'd28, 16'd28);
    set_rom(0); run_frame("hammer", 16'd1, 16'd1, 0, 1, 16'd8, 16'd8, 16'd8);

    // Abort while the second output index is being addressed
    load(16'd1, 16'd1, 0);
    t = 0;
    while (w_addr != 3'd2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_reach_o1", 32'(t < 50), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_in_rdy", in_rdy, 1);
    check("abort_busy", busy, 0);
    check("abort_new_sum", mac_new_sum, 0);
    check("abort_mac_data", mac_data, 0);
    check("abort_mac_w", mac_w, 0);
    check("abort_w_addr", w_addr, 0);
    check("abort_out", {out_data, 14'd0, out_idx}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    res_n = 0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_out", res_n, 0);
    check("abort_idle", in_rdy, 1);

    set_rom(0); run_frame("after", 16'd1, 16'd1, 0, 0, 16'd8, 16'd8, 16'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
